// File: rtl/cache_rd_arbiter_pkg.sv
// cache_rd_arbiter_pkg: shared state encodings, ARID/RRESP constants and the
// latched read-command payload for the cache read arbiter.
package cache_rd_arbiter_pkg;

   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DONE = 2'd3
   } rd_state_e;

   typedef enum logic [1:0] {
      GNT_IC = 2'd0,
      GNT_DC = 2'd1,
      GNT_UC = 2'd2
   } rd_gnt_e;

   localparam int unsigned ARID_IC = 0;
   localparam int unsigned ARID_DC = 1;
   localparam int unsigned ARID_UC = 2;

   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [2:0] ARSIZE_WORD  = 3'b010;
   localparam logic [1:0] ARBURST_INCR = 2'b01;

   // Command latched at grant time and held for the whole transaction.
   typedef struct packed {
      logic [AXI_ADDR_W-1:0] addr;
      logic [AXI_LEN_W-1:0]  len;
      rd_gnt_e               gnt;
   } rd_cmd_t;

   function automatic int unsigned gnt_to_arid(input rd_gnt_e gnt);
      case (gnt)
         GNT_DC:  return ARID_DC;
         GNT_UC:  return ARID_UC;
         default: return ARID_IC;
      endcase
   endfunction

endpackage

// File: rtl/cache_rd_arbiter_if.sv
// cache_rd_arbiter_if: AXI read address + read data channels.
//   master modport: the arbiter (drives AR payload/valid and rready).
//   slave modport : the AXI memory side (drives arready and the R channel).
interface cache_rd_arbiter_if
   import cache_rd_arbiter_pkg::*;
#(
   parameter int unsigned ID_W = 4
) ();

   logic [ID_W-1:0]       arid;
   logic [AXI_ADDR_W-1:0] araddr;
   logic [AXI_LEN_W-1:0]  arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [ID_W-1:0]       rid;
   logic [AXI_DATA_W-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/cache_rd_arbiter_rd_line_buffer.sv
// cache_rd_arbiter_rd_line_buffer (rd_line_buffer): beat-indexed 32-bit write
// port into a BEATS*32-bit line register with a synchronous clear.
//   clk, rst_n : clock, async active-low reset (line cleared)
//   clr_i      : synchronous clear of the whole line
//   we_i       : write word idx_i with wdata_i
//   line_o     : registered line, word k at [32k+31:32k]
module cache_rd_arbiter_rd_line_buffer #(
   parameter int unsigned BEATS = 8,
   parameter int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      idx_i,
   input  logic [31:0]           wdata_i,
   output logic [BEATS*32-1:0]   line_o
);

   logic [BEATS-1:0][31:0] line_q;

   // Word storage; unwritten words keep their previous contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else if (clr_i) begin
         line_q <= '0;
      end else if (we_i) begin
         line_q[idx_i] <= wdata_i;
      end
   end

   assign line_o = line_q;

endmodule

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: shares one AXI read channel between icache refill, dcache
// refill and (with RD_ARB_UNCACHED_EN defined) an uncached single-word port.
// Issues an 8-beat INCR burst per refill (1 beat uncached), assembles the
// line and pulses the granted requester's rend for one cycle.
//   clk, rst_n                 : clock, async active-low reset
//   ic_req_i/ic_addr_i/ic_rend_o : icache refill request/line address/done
//   dc_req_i/dc_addr_i/dc_rend_o : dcache refill request/line address/done
//   uc_req_i/uc_addr_i/uc_rend_o/uc_rdata_o : uncached port (RD_ARB_UNCACHED_EN)
//   line_rdata_o               : assembled line
//   rerr_o                     : error flag, valid with rend
//   busy_o                     : high outside IDLE
//   axi                        : AXI AR/R channels (master modport)
// All outputs are registered.
module cache_rd_arbiter
   import cache_rd_arbiter_pkg::*;
#(
   parameter int unsigned LINE_BEATS = 8,
   parameter int unsigned ID_W       = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ic_req_i,
   input  logic [31:0]               ic_addr_i,
   output logic                      ic_rend_o,
   input  logic                      dc_req_i,
   input  logic [31:0]               dc_addr_i,
   output logic                      dc_rend_o,
`ifdef RD_ARB_UNCACHED_EN
   input  logic                      uc_req_i,
   input  logic [31:0]               uc_addr_i,
   output logic                      uc_rend_o,
   output logic [31:0]               uc_rdata_o,
`endif
   output logic [LINE_BEATS*32-1:0]  line_rdata_o,
   output logic                      rerr_o,
   output logic                      busy_o,
   cache_rd_arbiter_if.master        axi
);

   localparam int unsigned IDX_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam logic [AXI_LEN_W-1:0] LEN_LINE = AXI_LEN_W'(LINE_BEATS - 1);

   rd_state_e            state_q;
   rd_cmd_t              cmd_q;
   logic                 last_dc_q;
   logic [AXI_LEN_W-1:0] beat_cnt_q;
   logic                 err_q;
   logic                 arvalid_q;
   logic                 rready_q;
   logic                 busy_q;
   logic                 ic_rend_q;
   logic                 dc_rend_q;
   logic                 rerr_q;
`ifdef RD_ARB_UNCACHED_EN
   logic                 uc_rend_q;
`endif

   logic                 req_any_d;
   rd_gnt_e              gnt_d;
   logic [31:0]          addr_d;
   logic [AXI_LEN_W-1:0] len_d;

   logic                 beat_final;
   logic                 beat_bad;
   logic                 buf_we;
   logic [LINE_BEATS*32-1:0] line_buf;

   // Arbitration: uncached first, then icache/dcache round-robin on ties.
   always_comb begin
      req_any_d = ic_req_i | dc_req_i;
      gnt_d     = GNT_DC;
      if (ic_req_i && dc_req_i) begin
         gnt_d = last_dc_q ? GNT_IC : GNT_DC;
      end else if (ic_req_i) begin
         gnt_d = GNT_IC;
      end
`ifdef RD_ARB_UNCACHED_EN
      if (uc_req_i) begin
         req_any_d = 1'b1;
         gnt_d     = GNT_UC;
      end
`endif
   end

   // Command payload for the winner.
   always_comb begin
      addr_d = (gnt_d == GNT_IC) ? ic_addr_i : dc_addr_i;
      len_d  = LEN_LINE;
`ifdef RD_ARB_UNCACHED_EN
      if (gnt_d == GNT_UC) begin
         addr_d = uc_addr_i;
         len_d  = '0;
      end
`endif
   end

   // A beat is bad on a non-OKAY response or when rlast disagrees with the
   // expected final beat (early rlast or missing rlast).
   assign beat_final = (beat_cnt_q == cmd_q.len);
   assign beat_bad   = (axi.rresp != RRESP_OKAY) | (axi.rlast != beat_final);
   assign buf_we     = (state_q == ST_R) & axi.rvalid;

   // Read FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         last_dc_q  <= 1'b1;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         busy_q     <= 1'b0;
         ic_rend_q  <= 1'b0;
         dc_rend_q  <= 1'b0;
         rerr_q     <= 1'b0;
`ifdef RD_ARB_UNCACHED_EN
         uc_rend_q  <= 1'b0;
`endif
      end else begin
         ic_rend_q <= 1'b0;
         dc_rend_q <= 1'b0;
         rerr_q    <= 1'b0;
`ifdef RD_ARB_UNCACHED_EN
         uc_rend_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (req_any_d) begin
                  cmd_q.addr <= addr_d;
                  cmd_q.len  <= len_d;
                  cmd_q.gnt  <= gnt_d;
                  arvalid_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ST_AR;
               end
            end
            ST_AR: begin
               if (axi.arready) begin
                  arvalid_q  <= 1'b0;
                  rready_q   <= 1'b1;
                  beat_cnt_q <= '0;
                  err_q      <= 1'b0;
                  state_q    <= ST_R;
               end
            end
            ST_R: begin
               if (axi.rvalid) begin
                  beat_cnt_q <= beat_cnt_q + AXI_LEN_W'(1);
                  if (beat_bad) begin
                     err_q <= 1'b1;
                  end
                  if (axi.rlast || beat_final) begin
                     rready_q  <= 1'b0;
                     rerr_q    <= err_q | beat_bad;
                     ic_rend_q <= (cmd_q.gnt == GNT_IC);
                     dc_rend_q <= (cmd_q.gnt == GNT_DC);
`ifdef RD_ARB_UNCACHED_EN
                     uc_rend_q <= (cmd_q.gnt == GNT_UC);
`endif
                     state_q   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (cmd_q.gnt != GNT_UC) begin
                  last_dc_q <= (cmd_q.gnt == GNT_DC);
               end
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Words persist across bursts, so a short burst leaves stale upper words.
   cache_rd_arbiter_rd_line_buffer #(
      .BEATS (LINE_BEATS),
      .IDX_W (IDX_W)
   ) u_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (1'b0),
      .we_i    (buf_we),
      .idx_i   (beat_cnt_q[IDX_W-1:0]),
      .wdata_i (axi.rdata),
      .line_o  (line_buf)
   );

   assign axi.arid    = ID_W'(gnt_to_arid(cmd_q.gnt));
   assign axi.araddr  = cmd_q.addr;
   assign axi.arlen   = cmd_q.len;
   assign axi.arsize  = ARSIZE_WORD;
   assign axi.arburst = ARBURST_INCR;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   assign ic_rend_o    = ic_rend_q;
   assign dc_rend_o    = dc_rend_q;
   assign rerr_o       = rerr_q;
   assign busy_o       = busy_q;
   assign line_rdata_o = line_buf;
`ifdef RD_ARB_UNCACHED_EN
   assign uc_rend_o    = uc_rend_q;
   assign uc_rdata_o   = line_buf[31:0];
`endif

   // Only one read is ever outstanding, so the returned ID carries no information.
   logic unused_rid;
   assign unused_rid = ^axi.rid;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Self-checking bench for cache_rd_arbiter: directed bursts, expected AR and
// rend responses queued by the stimulus, checked by a negedge monitor.
module tb_cache_rd_arbiter;

   localparam int unsigned ID_W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ic_req, dc_req;
   logic [31:0]  ic_addr, dc_addr;
   logic         ic_rend, dc_rend, rerr, busy;
   logic [255:0] line_rdata;
   logic         tb_uc_rend;
   logic [31:0]  tb_uc_rdata;
`ifdef RD_ARB_UNCACHED_EN
   logic         uc_req;
   logic [31:0]  uc_addr;
   logic         uc_rend;
   logic [31:0]  uc_rdata;
   assign tb_uc_rend  = uc_rend;
   assign tb_uc_rdata = uc_rdata;
`else
   assign tb_uc_rend  = 1'b0;
   assign tb_uc_rdata = '0;
`endif

   cache_rd_arbiter_if #(.ID_W(ID_W)) axi ();

   cache_rd_arbiter #(.LINE_BEATS(8), .ID_W(ID_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ic_req_i     (ic_req),
      .ic_addr_i    (ic_addr),
      .ic_rend_o    (ic_rend),
      .dc_req_i     (dc_req),
      .dc_addr_i    (dc_addr),
      .dc_rend_o    (dc_rend),
`ifdef RD_ARB_UNCACHED_EN
      .uc_req_i     (uc_req),
      .uc_addr_i    (uc_addr),
      .uc_rend_o    (uc_rend),
      .uc_rdata_o   (uc_rdata),
`endif
      .line_rdata_o (line_rdata),
      .rerr_o       (rerr),
      .busy_o       (busy),
      .axi          (axi)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int           which;
      logic [255:0] line;
      logic [31:0]  word;
      logic         err;
      int           cyc;
   } rend_exp_t;

   typedef struct {
      logic [31:0]     addr;
      logic [7:0]      len;
      logic [ID_W-1:0] id;
   } ar_exp_t;

   rend_exp_t    rend_q[$];
   ar_exp_t      ar_q[$];
   logic [255:0] model_line;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rend_of(input int which);
      case (which)
         0:       return ic_rend;
         1:       return dc_rend;
         default: return tb_uc_rend;
      endcase
   endfunction

   // Monitor: pops expectations whenever the DUT presents an AR handshake or a rend.
   ar_exp_t   mon_ar;
   rend_exp_t mon_r;
   int        mon_which;
   always @(negedge clk) begin
      if (rst_n) begin
         if (axi.arvalid && axi.arready) begin
            if (ar_q.size() == 0) begin
               fail_now("ar_unexpected");
            end else begin
               mon_ar = ar_q.pop_front();
               chk("araddr", 256'(axi.araddr), 256'(mon_ar.addr));
               chk("arlen",  256'(axi.arlen),  256'(mon_ar.len));
               chk("arid",   256'(axi.arid),   256'(mon_ar.id));
            end
         end
         if ((32'(ic_rend) + 32'(dc_rend) + 32'(tb_uc_rend)) > 32'd1) begin
            fail_now("rend_multiple");
         end
         if (rerr && !(ic_rend || dc_rend || tb_uc_rend)) begin
            fail_now("rerr_without_rend");
         end
         if (ic_rend || dc_rend || tb_uc_rend) begin
            if (rend_q.size() == 0) begin
               fail_now("rend_unexpected");
            end else begin
               mon_r     = rend_q.pop_front();
               mon_which = ic_rend ? 0 : (dc_rend ? 1 : 2);
               chk("rend_which", 256'(mon_which), 256'(mon_r.which));
               chk("rerr", 256'(rerr), 256'(mon_r.err));
               if (mon_r.which == 2) chk("uc_rdata", 256'(tb_uc_rdata), 256'(mon_r.word));
               else                  chk("line_rdata", line_rdata, mon_r.line);
               if (mon_r.cyc >= 0) chk("rend_cycle", 256'(cyc), 256'(mon_r.cyc));
            end
         end
      end
   end

   // AXI slave model for one burst; pushes the expected AR and rend first.
   task automatic serve(input int which, input logic [31:0] addr, input logic [7:0] len,
                        input int nbeats, input logic [31:0] base, input int ar_delay,
                        input int gap_mask, input int err_beat, input int last_beat,
                        input int abort_beat, input logic exp_err, input int exp_cyc);
      rend_exp_t    r;
      ar_exp_t      a;
      logic [255:0] nl;
      int           w;
      a.addr = addr;
      a.len  = len;
      a.id   = ID_W'(which);
      ar_q.push_back(a);
      nl = model_line;
      for (int i = 0; i < nbeats; i++) begin
         if (abort_beat < 0 || i < abort_beat) nl[i*32 +: 32] = base + 32'(i);
      end
      model_line = nl;
      if (abort_beat < 0) begin
         r.which = which;
         r.line  = nl;
         r.word  = base;
         r.err   = exp_err;
         r.cyc   = exp_cyc;
         rend_q.push_back(r);
      end
      w = 0;
      while (!axi.arvalid && w < 40) begin
         tick();
         w++;
      end
      if (!axi.arvalid) begin
         fail_now("arvalid_timeout");
         return;
      end
      for (int d = 0; d < ar_delay; d++) begin
         chk("araddr_stable", 256'(axi.araddr), 256'(addr));
         tick();
      end
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         if (gap_mask[i]) begin
            axi.rvalid = 1'b0;
            tick();
         end
         axi.rvalid = 1'b1;
         axi.rdata  = base + 32'(i);
         axi.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
         axi.rlast  = (i == last_beat);
         if (i == abort_beat) begin
            rst_n = 1'b0;
            return;
         end
         tick();
      end
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
   endtask

   task automatic wait_rend(input int which);
      int w = 0;
      while (!rend_of(which) && w < 80) begin
         tick();
         w++;
      end
      if (!rend_of(which)) fail_now("rend_timeout");
      tick();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},    256'(busy),        '0);
      chk({tag, "_arvalid"}, 256'(axi.arvalid), '0);
      chk({tag, "_rready"},  256'(axi.rready),  '0);
      chk({tag, "_ic_rend"}, 256'(ic_rend),     '0);
      chk({tag, "_dc_rend"}, 256'(dc_rend),     '0);
      chk({tag, "_uc_rend"}, 256'(tb_uc_rend),  '0);
      chk({tag, "_rerr"},    256'(rerr),        '0);
      chk({tag, "_line"},    line_rdata,        '0);
      chk({tag, "_uc_data"}, 256'(tb_uc_rdata), '0);
      chk({tag, "_araddr"},  256'(axi.araddr),  '0);
      chk({tag, "_arlen"},   256'(axi.arlen),   '0);
      chk({tag, "_arid"},    256'(axi.arid),    '0);
      chk({tag, "_arsize"},  256'(axi.arsize),  256'(3'b010));
      chk({tag, "_arburst"}, 256'(axi.arburst), 256'(2'b01));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   int c0;
   int w;
   initial begin
      rst_n       = 1'b0;
      ic_req      = 1'b0;
      dc_req      = 1'b0;
      ic_addr     = '0;
      dc_addr     = '0;
`ifdef RD_ARB_UNCACHED_EN
      uc_req      = 1'b0;
      uc_addr     = '0;
`endif
      axi.arready = 1'b0;
      axi.rid     = '0;
      axi.rdata   = '0;
      axi.rresp   = 2'b00;
      axi.rlast   = 1'b0;
      axi.rvalid  = 1'b0;
      model_line  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      tick();
      tick();

      // Tie from reset: icache first, then dcache.
      ic_addr = 32'h0000_0100;
      dc_addr = 32'h0000_0200;
      ic_req  = 1'b1;
      dc_req  = 1'b1;
      c0      = cyc;
      serve(0, 32'h0000_0100, 8'd7, 8, 32'h0000_1100, 0, 0, -1, 7, -1, 1'b0, c0 + 10);
      wait_rend(0);
      chk("busy_low_after_ic", 256'(busy), '0);
      ic_req = 1'b0;
      c0     = cyc;
      serve(1, 32'h0000_0200, 8'd7, 8, 32'h0000_2200, 0, 0, -1, 7, -1, 1'b0, c0 + 10);
      wait_rend(1);
      dc_req = 1'b0;

      // Single icache refill, best-case timing.
      ic_addr = 32'h1FC0_0020;
      ic_req  = 1'b1;
      c0      = cyc;
      serve(0, 32'h1FC0_0020, 8'd7, 8, 32'h0000_0000, 0, 0, -1, 7, -1, 1'b0, c0 + 10);
      wait_rend(0);
      chk("busy_low_n11", 256'(busy), '0);
      chk("cycle_n11", 256'(cyc), 256'(c0 + 11));
      chk("line_word7", 256'(line_rdata[255:224]), 256'(32'h7));
      ic_req = 1'b0;

      // Backpressure: arready after 3 cycles, gaps before beats 2 and 5, SLVERR on beat 4.
      dc_addr = 32'h0000_1000;
      dc_req  = 1'b1;
      serve(1, 32'h0000_1000, 8'd7, 8, 32'hA000_0000, 3, 32'h24, 4, 7, -1, 1'b1, -1);
      wait_rend(1);
      dc_req = 1'b0;

      // Early rlast on beat index 3: upper words keep the previous burst's data.
      ic_addr = 32'h2000_0040;
      ic_req  = 1'b1;
      serve(0, 32'h2000_0040, 8'd7, 4, 32'hC000_0000, 0, 0, -1, 3, -1, 1'b1, -1);
      wait_rend(0);
      ic_req = 1'b0;

      // Missing rlast on the final beat.
      dc_addr = 32'h2000_0080;
      dc_req  = 1'b1;
      serve(1, 32'h2000_0080, 8'd7, 8, 32'hB000_0000, 0, 0, -1, -1, -1, 1'b1, -1);
      wait_rend(1);
      dc_req = 1'b0;

      // Reset asserted while beat 5 is offered.
      ic_addr = 32'h3000_0000;
      ic_req  = 1'b1;
      serve(0, 32'h3000_0000, 8'd7, 8, 32'hD000_0000, 0, 0, -1, 7, 5, 1'b0, -1);
      #1;
      ic_req     = 1'b0;
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      model_line = '0;
      chk_idle_outputs("midrst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Fresh request after reset completes normally.
      ic_addr = 32'h3000_0100;
      ic_req  = 1'b1;
      c0      = cyc;
      serve(0, 32'h3000_0100, 8'd7, 8, 32'hE000_0000, 0, 0, -1, 7, -1, 1'b0, c0 + 10);
      wait_rend(0);
      ic_req = 1'b0;

`ifdef RD_ARB_UNCACHED_EN
      // Uncached beats icache; icache is served next.
      uc_addr = 32'h4000_0004;
      ic_addr = 32'h4000_0100;
      uc_req  = 1'b1;
      ic_req  = 1'b1;
      c0      = cyc;
      serve(2, 32'h4000_0004, 8'd0, 1, 32'hDEAD_BEEF, 0, 0, -1, 0, -1, 1'b0, c0 + 3);
      wait_rend(2);
      uc_req = 1'b0;
      c0     = cyc;
      serve(0, 32'h4000_0100, 8'd7, 8, 32'hF000_0000, 0, 0, -1, 7, -1, 1'b0, c0 + 10);
      wait_rend(0);
      ic_req = 1'b0;
`endif

      w = 0;
      while ((rend_q.size() != 0 || ar_q.size() != 0) && w < 50) begin
         tick();
         w++;
      end
      chk("rend_q_drained", 256'(rend_q.size()), '0);
      chk("ar_q_drained",   256'(ar_q.size()),   '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_rd_arbiter.md
# cache_rd_arbiter

Shares the single AXI read channel among the icache refill path, the dcache refill path and, optionally, an uncached single-word read port. It grants one requester at a time and issues the AR burst: 8×32-bit INCR for a cache line, 1 beat for uncached. It assembles the R beats into a 256-bit line and returns a one-cycle completion pulse to the granted requester. It sits between the cache stage-2 miss logic and the AXI master interface.

## Interface
- `LINE_BEATS`, default 8: beats per cacheline refill; line width = `LINE_BEATS*32`.
- `ID_W`, default 4: width of the AXI ID.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ic_req_i`  in  1  icache refill request; level, held until `ic_rend_o`.
- `ic_addr_i`  in  32  icache line address; bits [4:0] are 0.
- `ic_rend_o`  out  1  one-cycle pulse; line is valid on `line_rdata_o`.
- `dc_req_i` / `dc_addr_i` / `dc_rend_o`: same as the icache set, for the dcache.
- `uc_req_i`  in  1  uncached read request (only with `RD_ARB_UNCACHED_EN`).
- `uc_addr_i`  in  32  word address (only with `RD_ARB_UNCACHED_EN`).
- `uc_rend_o`  out  1  completion pulse (only with `RD_ARB_UNCACHED_EN`).
- `uc_rdata_o`  out  32  uncached word, valid with `uc_rend_o` (only with `RD_ARB_UNCACHED_EN`).
- `line_rdata_o`  out  256  assembled line; word k at bits [32k+31:32k].
- `rerr_o`  out  1  pulse with rend when the burst had an error.
- `busy_o`  out  1  high in every state except IDLE.
- `arid_o`  out  `ID_W`  0 = icache, 1 = dcache, 2 = uncached.
- `araddr_o`  out  32  burst start address.
- `arlen_o`  out  8  `LINE_BEATS-1` for a refill, 0 for uncached.
- `arsize_o`  out  3  constant 3'b010.
- `arburst_o`  out  2  constant 2'b01 (INCR).
- `arvalid_o`  out  1  AR channel valid.
- `arready_i`  in  1  AR channel ready.
- `rid_i`  in  `ID_W`  R channel ID; ignored, since only one read is ever outstanding.
- `rdata_i`  in  32  R channel data.
- `rresp_i`  in  2  R channel response.
- `rlast_i`  in  1  R channel last beat.
- `rvalid_i`  in  1  R channel valid.
- `rready_o`  out  1  R channel ready.

## Operation
- FSM states: IDLE, AR, R, DONE.
- **IDLE**
  - Samples the requests. Uncached wins over both caches.
  - Ties between icache and dcache are round-robin via `last_grant`. Reset value of `last_grant` is dcache, so icache wins the first tie.
  - On a grant: latch grant, address, `arlen` and `arid`; go to AR.
  - With no request, stay in IDLE.
- **AR**
  - `arvalid_o=1`, with address, length and ID held stable.
  - On `arvalid_o & arready_i`: clear `beat_cnt` and `err`; go to R.
- **R**
  - `rready_o=1`.
  - Each `rvalid_i` writes `rdata_i` into word `beat_cnt` and increments `beat_cnt`.
  - `err` is set if `rresp_i!=2'b00`.
  - Leave for DONE on `rlast_i`, or when `beat_cnt==arlen` is accepted, whichever comes first.
  - `rlast_i` early: set `err`; the remaining words keep their previous contents.
  - `rlast_i` missing on the final beat: set `err`; exit anyway.
- **DONE**
  - One cycle. Raise the granted `*_rend_o`, `rerr_o=err`, and `line_rdata_o`/`uc_rdata_o` from registered buffers.
  - Update `last_grant` if a cache was served. Go to IDLE.
- Requester rule: the requester deasserts `req` in the cycle after its rend. IDLE does not re-sample until that cycle, so no duplicate grant is issued.
- **Reset, including mid-burst:** FSM to IDLE; every output 0 except the constants `arsize_o`/`arburst_o`; line buffer 0. The AXI slave shares `rst_n`.

## Timing
- Request seen in IDLE at cycle N: `arvalid_o` at N+1.
- With `arready_i` high immediately and back-to-back beats:
  - beats accepted at N+2 through N+9;
  - `*_rend_o` at N+10;
  - `busy_o` low at N+11.
- Uncached best case: beat at N+2, rend at N+3.
- `arready_i` high in the same cycle as `arvalid_o` rises: AR lasts exactly 1 cycle.
- `rready_o` is 0 in IDLE, AR and DONE; beats offered in those states are not accepted.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- `RD_ARB_UNCACHED_EN` defined: the uncached port exists with top priority, and DONE drives `uc_rdata_o` from word 0.
- Undefined: the uc ports are absent, arbitration is icache/dcache round-robin only, and `arlen_o` is always `LINE_BEATS-1`.

## Structure
- Shared defines header `defines_cache.v` holds:
  - FSM state encodings;
  - ARID constants `ARID_IC`, `ARID_DC`, `ARID_UC`;
  - `RRESP_OKAY`;
  - the existing `WayBus`/`DataAddrBus` widths.
- One sub-module, `rd_line_buffer`: a beat-indexed 32-bit write port into a 256-bit register, with a clear input. FSM and arbitration stay at top level.

## Test plan
- **Single icache refill:** icache requests 0x1FC0_0020, ready always high, data 0x0..0x7. Required: `araddr=0x1FC0_0020`, `arlen=7`, `arid=0`; `ic_rend_o` at N+10; `line_rdata_o[255:224]=0x7`.
- **Tie round-robin:** icache and dcache both request from reset. Required: icache served first, then dcache; each sees exactly one rend.
- **Uncached priority** (`RD_ARB_UNCACHED_EN`): uncached and icache request together, uncached word 0xDEADBEEF. Required: `arlen=0`; `uc_rdata_o=0xDEADBEEF` at N+3; icache served next.
- **Backpressure and error:** `arready` delayed 3 cycles, `rvalid` gapped, beat 4 `rresp=2'b10`. Required: `araddr` stable through AR, 8 beats captured, `rerr_o=1` with rend.
- **Early `rlast` / reset mid-burst:** `rlast` on beat 3. Required: DONE with `rerr_o=1`. A separate run asserts `rst_n` low at beat 5. Required: all outputs 0 and state IDLE, then a fresh request completes normally.
